// File: rtl/dmem_io_pkg.sv
// Shared definitions for the data-memory responder: IO offsets, timer
// control bit positions and the address region decode.
package dmem_io_pkg;

    localparam logic [7:0] OFF_SWITCHES      = 8'h00;
    localparam logic [7:0] OFF_BUTTONS       = 8'h04;
    localparam logic [7:0] OFF_BTN_EDGE      = 8'h08;
    localparam logic [7:0] OFF_LEDS          = 8'h0C;
    localparam logic [7:0] OFF_TIMER_COUNT   = 8'h10;
    localparam logic [7:0] OFF_TIMER_COMPARE = 8'h14;
    localparam logic [7:0] OFF_TIMER_CTRL    = 8'h18;
    localparam logic [7:0] OFF_TIMER_STATUS  = 8'h1C;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int STATUS_MATCH    = 0;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_IO,
        REG_NONE
    } region_e;

    // RAM takes priority so a low IO_BASE can never shadow data memory.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes,
                                              input logic [23:0] io_page);
        region_e r;
        if (addr < ram_bytes)
            r = REG_RAM;
        else if (addr[31:8] == io_page)
            r = REG_IO;
        else
            r = REG_NONE;
        return r;
    endfunction

endpackage

// File: rtl/io_timer.sv
// Prescaled compare timer behind the peripheral window: count, compare,
// control and sticky match status, with a single word write port.
module io_timer
    import dmem_io_pkg::*;
#(
    parameter int PRESCALE = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [7:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  raddr_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   cmp_q, cmp_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          match_q, match_d;
    logic          tick, hit;
    logic          wr_count, wr_cmp, wr_ctrl, clr_match;

    assign wr_count  = we_i && (waddr_i == OFF_TIMER_COUNT);
    assign wr_cmp    = we_i && (waddr_i == OFF_TIMER_COMPARE);
    assign wr_ctrl   = we_i && (waddr_i == OFF_TIMER_CTRL);
    assign clr_match = we_i && (waddr_i == OFF_TIMER_STATUS) && wdata_i[STATUS_MATCH];

    assign tick = ctrl_q[CTRL_EN] && (pre_q == PRE_LAST);
    assign hit  = tick && (count_q == cmp_q);

    always_comb begin
        pre_d   = pre_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;

        if (!ctrl_q[CTRL_EN] || tick)
            pre_d = '0;
        else
            pre_d = pre_q + 1'b1;

        if (tick) begin
            if (!hit)
                count_d = count_q + 32'd1;
            else if (ctrl_q[CTRL_AUTORELOAD])
                count_d = '0;
            else
                ctrl_d[CTRL_EN] = 1'b0;
        end

        // Software writes land after the tick update so they take precedence.
        if (wr_count)
            count_d = wdata_i;
        if (wr_cmp)
            cmp_d = wdata_i;
        if (wr_ctrl) begin
            ctrl_d = wdata_i[1:0];
            pre_d  = '0;
        end

        match_d = (match_q && !clr_match) || hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q   <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            ctrl_q  <= '0;
            match_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            OFF_TIMER_COUNT:   rdata_o = count_q;
            OFF_TIMER_COMPARE: rdata_o = cmp_q;
            OFF_TIMER_CTRL:    rdata_o = {30'd0, ctrl_q};
            OFF_TIMER_STATUS:  rdata_o = {31'd0, match_q};
            default:           rdata_o = '0;
        endcase
    end

    assign irq_o = match_q;

endmodule

// File: rtl/dmem_io_bus.sv
// Data-memory port responder: word RAM plus a peripheral window with
// synchronized switches/buttons, button edge capture, LEDs and a timer.
module dmem_io_bus
    import dmem_io_pkg::*;
#(
    parameter int          RAM_WORDS = 64,
    parameter logic [31:0] IO_BASE   = 32'hC000_0000,
    parameter int          PRESCALE  = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic [9:0]  switches,
    input  logic [3:0]  buttons,
    output logic [9:0]  leds,
    output logic        timer_irq
);

    localparam int AW = $clog2(RAM_WORDS);

    region_e       region;
    logic [7:0]    io_off;
    logic          io_we;
    logic [AW-1:0] ram_idx;
    logic [31:0]   mem_q [RAM_WORDS];

    logic [9:0]  sw_s1_q, sw_s2_q;
    logic [3:0]  btn_s1_q, btn_s2_q, btn_s3_q;
    logic [3:0]  edge_q, edge_d;
    logic [9:0]  led_q, led_d;
    logic [31:0] tmr_rdata, io_rdata;

    assign region  = decode_region(Address, 32'(4 * RAM_WORDS), IO_BASE[31:8]);
    assign io_off  = {Address[7:2], 2'b00};
    assign io_we   = MemWrite && (region == REG_IO);
    assign ram_idx = Address[AW+1:2];

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (MemWrite && (region == REG_RAM))
            mem_q[ram_idx] <= WriteData;
    end

    always_comb begin
        edge_d = edge_q;
        led_d  = led_q;
        if (io_we && (io_off == OFF_BTN_EDGE))
            edge_d = edge_q & ~WriteData[3:0];
        // A fresh rise is OR'd in after the clear, so a same-cycle set wins.
        edge_d = edge_d | (btn_s2_q & ~btn_s3_q);
        if (io_we && (io_off == OFF_LEDS))
            led_d = WriteData[9:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            btn_s3_q <= '0;
            edge_q   <= '0;
            led_q    <= '0;
        end else begin
            sw_s1_q  <= switches;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= buttons;
            btn_s2_q <= btn_s1_q;
            btn_s3_q <= btn_s2_q;
            edge_q   <= edge_d;
            led_q    <= led_d;
        end
    end

    io_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .we_i    (io_we),
        .waddr_i (io_off),
        .wdata_i (WriteData),
        .raddr_i (io_off),
        .rdata_o (tmr_rdata),
        .irq_o   (timer_irq)
    );

    always_comb begin
        io_rdata = '0;
        case (io_off)
            OFF_SWITCHES: io_rdata = {22'd0, sw_s2_q};
            OFF_BUTTONS:  io_rdata = {28'd0, btn_s2_q};
            OFF_BTN_EDGE: io_rdata = {28'd0, edge_q};
            OFF_LEDS:     io_rdata = {22'd0, led_q};
            default:      io_rdata = tmr_rdata;
        endcase
    end

    always_comb begin
        ReadData = '0;
        case (region)
            REG_RAM: ReadData = mem_q[ram_idx];
            REG_IO:  ReadData = io_rdata;
            default: ReadData = '0;
        endcase
    end

    assign leds = led_q;

endmodule

// File: tb/tb_dmem_io_bus.sv
// Directed plus random bench for dmem_io_bus against a cycle-level
// behavioural model of the memory map, synchronizers and timer.
module tb_dmem_io_bus;

    localparam int          RAM_WORDS = 64;
    localparam logic [31:0] IO_BASE   = 32'hC000_0000;
    localparam int          PRESCALE  = 2;
    localparam int          AW        = $clog2(RAM_WORDS);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic [9:0]  switches = '0;
    logic [3:0]  buttons = '0;
    logic [9:0]  leds;
    logic        timer_irq;

    int n_chk = 0;
    int n_err = 0;
    bit live = 1'b0;

    dmem_io_bus #(
        .RAM_WORDS (RAM_WORDS),
        .IO_BASE   (IO_BASE),
        .PRESCALE  (PRESCALE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .switches  (switches),
        .buttons   (buttons),
        .leds      (leds),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    // Reference state: m_sw[1] / m_bh[1] are the synchronized values,
    // m_run counts enabled cycles since the last enable or CTRL write.
    logic [31:0] m_ram [RAM_WORDS];
    bit          m_vld [RAM_WORDS];
    logic [9:0]  m_sw  [2];
    logic [3:0]  m_bh  [3];
    logic [3:0]  m_edge;
    logic [9:0]  m_led;
    logic [31:0] m_cnt, m_cmp;
    logic        m_en, m_ar, m_match;
    int          m_run;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        if (a < 32'(4 * RAM_WORDS))
            r = m_ram[a[AW+1:2]];
        else if (a[31:8] == IO_BASE[31:8]) begin
            case (a[7:2])
                6'd0: r = {22'd0, m_sw[1]};
                6'd1: r = {28'd0, m_bh[1]};
                6'd2: r = {28'd0, m_edge};
                6'd3: r = {22'd0, m_led};
                6'd4: r = m_cnt;
                6'd5: r = m_cmp;
                6'd6: r = {30'd0, m_ar, m_en};
                6'd7: r = {31'd0, m_match};
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    task automatic mclock(input logic rst, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [9:0] sw, input logic [3:0] bt);
        logic       io;
        logic [5:0] w;
        bit         tick, hit;
        if (rst) begin
            m_sw = '{default: '0};
            m_bh = '{default: '0};
            m_edge = '0; m_led = '0; m_cnt = '0; m_cmp = '0;
            m_en = 1'b0; m_ar = 1'b0; m_match = 1'b0; m_run = 0;
            return;
        end
        io = (a >= 32'(4 * RAM_WORDS)) && (a[31:8] == IO_BASE[31:8]);
        w  = a[7:2];
        tick = m_en && (((m_run + 1) % PRESCALE) == 0);
        m_run = m_en ? m_run + 1 : 0;
        hit = tick && (m_cnt == m_cmp);
        if (tick) begin
            if (!hit)     m_cnt = m_cnt + 32'd1;
            else if (m_ar) m_cnt = '0;
            else          m_en = 1'b0;
        end
        if (we && io) begin
            case (w)
                6'd2: m_edge = m_edge & ~d[3:0];
                6'd3: m_led = d[9:0];
                6'd4: m_cnt = d;
                6'd5: m_cmp = d;
                6'd6: begin m_en = d[0]; m_ar = d[1]; m_run = 0; end
                6'd7: if (d[0]) m_match = 1'b0;
                default: ;
            endcase
        end
        if (hit) m_match = 1'b1;
        m_edge = m_edge | (m_bh[1] & ~m_bh[2]);
        m_bh[2] = m_bh[1]; m_bh[1] = m_bh[0]; m_bh[0] = bt;
        m_sw[1] = m_sw[0]; m_sw[0] = sw;
        if (we && (a < 32'(4 * RAM_WORDS))) begin
            m_ram[a[AW+1:2]] = d;
            m_vld[a[AW+1:2]] = 1'b1;
        end
    endtask

    // One bus cycle, entered and left at the falling edge.
    task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd);
        MemWrite = we; Address = a; WriteData = d;
        #1;
        rd = ReadData;
        if (live) begin
            if (!((a < 32'(4 * RAM_WORDS)) && !m_vld[a[AW+1:2]]))
                chk("rdata", ReadData, mread(a));
            chk("leds", {22'd0, leds}, {22'd0, m_led});
            chk("irq", {31'd0, timer_irq}, {31'd0, m_match});
        end
        @(posedge clk);
        mclock(reset, we, a, d, switches, buttons);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] v, a, d;
        logic        we;
        int          sel;
        m_vld = '{default: 1'b0};
        m_ram = '{default: '0};
        @(negedge clk);

        // reset state
        reset = 1'b1;
        cyc(0, 0, 0, v);
        cyc(0, 0, 0, v);
        reset = 1'b0;
        live = 1'b1;
        chk("rst_leds", {22'd0, leds}, 32'd0);
        chk("rst_irq", {31'd0, timer_irq}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, IO_BASE + 32'(4 * i), 0, v);
            chk("rst_io", v, 32'd0);
        end

        // RAM
        cyc(1, 32'h10, 32'hDEAD_BEEF, v);
        cyc(1, 32'h14, 32'h1234_5678, v);
        cyc(0, 32'h10, 0, v); chk("ram10", v, 32'hDEAD_BEEF);
        cyc(0, 32'h14, 0, v); chk("ram14", v, 32'h1234_5678);
        cyc(0, 32'h13, 0, v); chk("ram13", v, 32'hDEAD_BEEF);

        // unmapped and LEDS
        cyc(1, 32'h8000_0000, 32'hFFFF_FFFF, v);
        cyc(0, 32'h8000_0000, 0, v); chk("unmapped", v, 32'd0);
        cyc(1, IO_BASE + 32'h0C, 32'hFFFF_F2A5, v);
        cyc(0, IO_BASE + 32'h0C, 0, v); chk("leds_rd", v, 32'h0000_02A5);
        chk("leds_pin", {22'd0, leds}, 32'h0000_02A5);

        // button edge latency, hold, W1C, set-wins
        buttons = 4'h4;
        for (int i = 0; i < 4; i++) begin
            cyc(0, IO_BASE + 32'h08, 0, v);
            chk("btn_lat", v, (i == 3) ? 32'h4 : 32'h0);
        end
        buttons = 4'h0;
        repeat (4) cyc(0, IO_BASE + 32'h08, 0, v);
        chk("btn_hold", v, 32'h4);
        cyc(1, IO_BASE + 32'h08, 32'h4, v);
        cyc(0, IO_BASE + 32'h08, 0, v); chk("btn_w1c", v, 32'h0);
        buttons = 4'h4;
        cyc(0, IO_BASE, 0, v);
        cyc(0, IO_BASE, 0, v);
        cyc(1, IO_BASE + 32'h08, 32'h4, v);
        cyc(0, IO_BASE + 32'h08, 0, v); chk("btn_setwins", v, 32'h4);
        buttons = 4'h0;

        // timer one-shot
        cyc(1, IO_BASE + 32'h14, 32'd3, v);
        cyc(1, IO_BASE + 32'h10, 32'd0, v);
        cyc(1, IO_BASE + 32'h18, 32'h1, v);
        for (int i = 0; i < 8; i++) begin
            chk("t4_irq_lo", {31'd0, timer_irq}, 32'd0);
            cyc(0, IO_BASE + 32'h10, 0, v);
        end
        chk("t4_irq_hi", {31'd0, timer_irq}, 32'd1);
        repeat (3) cyc(0, IO_BASE + 32'h10, 0, v);
        chk("t4_count", v, 32'd3);
        cyc(0, IO_BASE + 32'h18, 0, v); chk("t4_ctrl", v, 32'd0);
        cyc(1, IO_BASE + 32'h1C, 32'd1, v);
        chk("t4_clr", {31'd0, timer_irq}, 32'd0);

        // timer auto-reload
        cyc(1, IO_BASE + 32'h14, 32'd1, v);
        cyc(1, IO_BASE + 32'h10, 32'd0, v);
        cyc(1, IO_BASE + 32'h18, 32'h3, v);
        for (int i = 0; i < 8; i++) begin
            cyc(0, IO_BASE + 32'h10, 0, v);
            chk("t5_seq", v, 32'((i / 2) % 2));
        end
        chk("t5_match", {31'd0, timer_irq}, 32'd1);
        cyc(1, IO_BASE + 32'h1C, 32'd1, v);
        chk("t5_clr", {31'd0, timer_irq}, 32'd0);
        cyc(0, IO_BASE + 32'h10, 0, v);
        cyc(0, IO_BASE + 32'h10, 0, v);
        cyc(1, IO_BASE + 32'h1C, 32'd1, v);
        chk("t5_clr_on_hit", {31'd0, timer_irq}, 32'd1);

        // reset mid-count
        cyc(1, IO_BASE + 32'h14, 32'hFFFF, v);
        cyc(1, IO_BASE + 32'h0C, 32'h3FF, v);
        cyc(1, IO_BASE + 32'h18, 32'h1, v);
        cyc(1, IO_BASE + 32'h10, 32'd5, v);
        reset = 1'b1;
        cyc(0, IO_BASE + 32'h10, 0, v);
        reset = 1'b0;
        cyc(0, IO_BASE + 32'h10, 0, v); chk("t6_count", v, 32'd0);
        cyc(0, IO_BASE + 32'h18, 0, v); chk("t6_ctrl", v, 32'd0);
        chk("t6_leds", {22'd0, leds}, 32'd0);
        chk("t6_irq", {31'd0, timer_irq}, 32'd0);
        cyc(0, 32'h10, 0, v); chk("t6_ram", v, 32'hDEAD_BEEF);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) switches = 10'($urandom);
            if ($urandom_range(0, 3) == 0) buttons = 4'($urandom);
            sel = int'($urandom_range(0, 9));
            if (sel < 4)
                a = 32'($urandom_range(0, RAM_WORDS * 4 - 1));
            else if (sel < 9)
                a = IO_BASE + 32'($urandom_range(0, 63));
            else
                a = $urandom;
            d  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 7));
            we = ($urandom_range(0, 2) == 0);
            cyc(we, a, d, v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_io_bus.md
Name: dmem_io_bus

Overview:
Responder for the single-cycle processor's data-memory port. The core drives address, write data and the write strobe, and receives read data. This block decodes the address into two regions: an internal data RAM and a memory-mapped peripheral window. The window holds synchronized switches and buttons, button edge capture, an LED register and a prescaled compare timer. Reads are combinational, as single-cycle load timing requires; all writes and state updates happen on the rising clock edge.

Parameters:
RAM_WORDS, 64, number of 32-bit words in the data RAM (power of two)
IO_BASE, 32'hC000_0000, base address of the peripheral window (decoded on Address[31:8])
PRESCALE, 50, timer tick divider in clk cycles (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
MemWrite  input  1  write strobe from the core, sampled on the rising edge
Address  input  32  byte address from the core's ALU result; bits [1:0] are ignored
WriteData  input  32  store data
ReadData  output  32  load data, combinational from Address
switches  input  10  raw board switches, asynchronous
buttons  input  4  raw push buttons, asynchronous, active-high
leds  output  10  LED register bits [9:0]
timer_irq  output  1  copy of TIMER_STATUS bit0

Behaviour:
Clock and reset:
- One clock, clk. Reset is synchronous and active-high.
- Reset clears all registers, synchronizers, edge bits and the timer, so leds=0 and timer_irq=0.
- RAM contents are not reset.

Address decode, word-aligned:
- RAM region: Address < 4*RAM_WORDS. Index is Address[log2(RAM_WORDS)+1:2].
- IO region: Address[31:8]==IO_BASE[31:8]. Offset is Address[7:0].
- Anything else reads 0 and ignores writes. There is no error response.

Reads:
- ReadData is combinational from the current register and RAM state.
- A same-cycle write is not visible until the next cycle.

Writes:
- A write occurs at the rising edge when MemWrite=1.
- Full 32-bit word writes only; there are no byte enables.

IO map (offset, name, access):
- 0x00 SWITCHES, RO: synchronized switches, zero-extended.
- 0x04 BUTTONS, RO: synchronized button levels.
- 0x08 BTN_EDGE, RO/W1C: bit i is set on a 0->1 transition of synchronized button i. Writing 1 clears the bit. If a set and a clear hit the same bit in the same cycle, set wins.
- 0x0C LEDS, RW: bits [9:0] are stored, upper bits read 0. The leds output drives directly from this register.
- 0x10 TIMER_COUNT, RW: a write loads the count.
- 0x14 TIMER_COMPARE, RW.
- 0x18 TIMER_CTRL, RW: bit0 EN, bit1 AUTORELOAD. Other bits read 0.
- 0x1C TIMER_STATUS, W1C: bit0 MATCH.
- Unlisted offsets read 0.

Synchronizers:
- switches and buttons each pass through 2 flops.
- Button edge detection uses a third flop, so a raw rise shows in BTN_EDGE 3 cycles later.

Timer:
- The prescaler counts 0..PRESCALE-1 while EN=1 and emits a 1-cycle tick at PRESCALE-1. It holds at 0 while EN=0.
- On a tick with COUNT!=COMPARE: COUNT increments, wrapping 0xFFFFFFFF->0.
- On a tick with COUNT==COMPARE:
  - MATCH is set.
  - If AUTORELOAD=1, COUNT becomes 0.
  - Otherwise COUNT holds and EN clears.
- A software write to COUNT or CTRL in the same cycle as a tick wins over the tick. A MATCH set still happens if that tick matched.
- A W1C of MATCH in the same cycle as a new match leaves MATCH=1.
- Writing CTRL resets the prescaler to 0.

Decomposition:
- Shared package dmem_io_pkg holds:
  - IO offset localparams (OFF_SWITCHES ... OFF_TIMER_STATUS)
  - CTRL bit indices
  - the region-select enum {REG_RAM, REG_IO, REG_NONE}
- One natural sub-module, io_timer: prescaler, count, compare, ctrl, status, plus a write-port interface. It is instantiated once inside dmem_io_bus.
- The synchronizers and RAM stay inline.

Test Plan:
1. RAM: write 0xDEADBEEF to 0x0000_0010 and 0x1234_5678 to 0x0000_0014, then read both -> exact values. Read 0x0000_0013 -> 0xDEADBEEF (low bits ignored).
2. Unmapped and LEDS: write 0xFFFF_FFFF to 0x8000_0000, then read -> 0. Write 0xFFFF_F2A5 to IO_BASE+0x0C -> leds=10'h2A5, readback 0x0000_02A5.
3. Buttons: raise buttons[2] -> BTN_EDGE reads 0x4 from the 3rd cycle on, staying set after release. Write 0x4 to +0x08 -> reads 0. Assert edge and W1C in the same cycle -> bit stays 1.
4. Timer one-shot, PRESCALE=2: COMPARE=3, COUNT=0, CTRL=0x1.
   - MATCH and timer_irq rise 8 cycles after the CTRL write.
   - COUNT holds at 3, CTRL reads 0.
   - Write 1 to STATUS -> timer_irq=0.
5. Timer auto-reload: COMPARE=1, CTRL=0x3 -> COUNT sequence 0,1,0,1 per tick, and MATCH stays set. Clearing MATCH on a matching tick -> MATCH=1.
6. Reset mid-count: assert reset with COUNT=5, EN=1, leds=0x3FF -> the next cycle reads COUNT=0, CTRL=0, leds=0, timer_irq=0, and RAM data is retained.
